// File: rtl/axi_rd_arbiter_pkg.sv
// ============================================================================
// axi_rd_arbiter_pkg : shared encodings and AXI constants for the read arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_t;

  // The owner encoding is also the AXI transaction ID.
  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

  function automatic logic [3:0] owner_to_id(input owner_t own);
    return {3'b000, own};
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_rd_arbiter_if.sv
// ============================================================================
// axi_rd_arbiter_if : AXI4 read address / read data channel bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface axi_rd_arbiter_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

`default_nettype wire

// File: rtl/axi_rd_arbiter_arb2_rr.sv
// ============================================================================
// arb2_rr : two-input round-robin grant, instruction side wins the first tie
// Revision: 1.0
// ============================================================================
`default_nettype none

module arb2_rr
  import axi_rd_arbiter_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic req_inst,
  input  wire logic req_data,
  input  wire logic update,
  output logic      grant_inst,
  output logic      grant_data
);

  owner_t last_grant;

  always_comb begin
    grant_inst = req_inst & (~req_data | (last_grant == OWN_DATA));
    grant_data = req_data & (~req_inst | (last_grant == OWN_INST));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= OWN_DATA;
    end else if (update) begin
      last_grant <= grant_data ? OWN_DATA : OWN_INST;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
// ============================================================================
// axi_rd_arbiter : shares one AXI4 read channel between fetch and load,
//                  single-beat reads, one outstanding, flush drains fetches
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        flush,
  input  wire logic        inst_req_valid,
  input  wire logic [31:0] inst_req_addr,
  output logic             inst_req_ready,
  output logic             inst_rdata_valid,
  output logic [31:0]      inst_rdata,
  input  wire logic        data_req_valid,
  input  wire logic [31:0] data_req_addr,
  input  wire logic [2:0]  data_req_size,
  output logic             data_req_ready,
  output logic             data_rdata_valid,
  output logic [31:0]      data_rdata,
  output logic             bus_err,
  output logic             busy,
  axi_rd_arbiter_if.master axi
);

  state_t      state;
  state_t      state_nxt;
  owner_t      owner;
  logic        discard;
  logic [31:0] ar_addr;
  logic [2:0]  ar_size;
  logic [3:0]  ar_id;
  logic        grant_inst;
  logic        grant_data;
  logic        inst_acc;
  logic        data_acc;
  logic        accept;
  logic        ar_hs;
  logic        r_hs;
  logic        inst_drop;
  logic        idle;

  // Masking the fetch request during flush lets a waiting load win that cycle.
  arb2_rr u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_inst   (inst_req_valid & ~flush),
    .req_data   (data_req_valid),
    .update     (accept),
    .grant_inst (grant_inst),
    .grant_data (grant_data)
  );

  assign idle           = (state == ST_IDLE);
  assign inst_req_ready = idle & grant_inst;
  assign data_req_ready = idle & grant_data;
  assign inst_acc       = inst_req_valid & inst_req_ready;
  assign data_acc       = data_req_valid & data_req_ready;
  assign accept         = inst_acc | data_acc;
  assign ar_hs          = (state == ST_AR) & axi.arready;
  assign r_hs           = (state == ST_R) & axi.rvalid;
  // A flush landing on the handshake cycle itself must still cancel the beat.
  assign inst_drop      = (owner == OWN_INST) & (discard | flush);

  assign busy        = ~idle;
  assign axi.arvalid = (state == ST_AR);
  assign axi.rready  = (state == ST_R);
  assign axi.araddr  = ar_addr;
  assign axi.arsize  = ar_size;
  assign axi.arid    = ar_id;
  assign axi.arlen   = LEN_SINGLE;
  assign axi.arburst = BURST_INCR;

  // One beat outstanding: rid and rlast carry no steering information.
  logic unused_axi;
  assign unused_axi = ^{axi.rid, axi.rlast};

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_AR;
      ST_AR:   if (ar_hs)  state_nxt = ST_R;
      ST_R:    if (r_hs)   state_nxt = ST_IDLE;
      default:             state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner            <= OWN_INST;
      ar_addr          <= 32'd0;
      ar_size          <= SIZE_WORD;
      ar_id            <= 4'd0;
      discard          <= 1'b0;
      inst_rdata       <= 32'd0;
      data_rdata       <= 32'd0;
      inst_rdata_valid <= 1'b0;
      data_rdata_valid <= 1'b0;
      bus_err          <= 1'b0;
    end else begin
      inst_rdata_valid <= 1'b0;
      data_rdata_valid <= 1'b0;
      bus_err          <= 1'b0;

      if (accept) begin
        owner   <= data_acc ? OWN_DATA : OWN_INST;
        ar_addr <= data_acc ? data_req_addr : inst_req_addr;
        ar_size <= data_acc ? data_req_size : SIZE_WORD;
        ar_id   <= owner_to_id(data_acc ? OWN_DATA : OWN_INST);
      end

      if (r_hs) begin
        discard <= 1'b0;
        if (owner == OWN_DATA) begin
          data_rdata       <= axi.rdata;
          data_rdata_valid <= 1'b1;
          bus_err          <= (axi.rresp != RESP_OKAY);
        end else if (!inst_drop) begin
          inst_rdata       <= axi.rdata;
          inst_rdata_valid <= 1'b1;
          bus_err          <= (axi.rresp != RESP_OKAY);
        end
      end else if (!idle && flush && (owner == OWN_INST)) begin
        discard <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
// ============================================================================
// tb_axi_rd_arbiter : vector table plus scoreboard bench for axi_rd_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axi_rd_arbiter;

  localparam int WAIT_MAX = 50;

  typedef struct {
    logic        inst_v;
    logic        data_v;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [2:0]  dsize;
    int          ar_dly;
    int          r_dly;
    logic [31:0] rdat;
    logic [1:0]  resp;
    logic        flush_ar;
    logic        flush_r;
    logic        hold_data;
    logic        exp_owner;
  } vec_t;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        inst_req_valid = 1'b0;
  logic [31:0] inst_req_addr = 32'd0;
  logic        inst_req_ready;
  logic        inst_rdata_valid;
  logic [31:0] inst_rdata;
  logic        data_req_valid = 1'b0;
  logic [31:0] data_req_addr = 32'd0;
  logic [2:0]  data_req_size = 3'd0;
  logic        data_req_ready;
  logic        data_rdata_valid;
  logic [31:0] data_rdata;
  logic        bus_err;
  logic        busy;

  axi_rd_arbiter_if bus ();

  axi_rd_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .inst_req_valid   (inst_req_valid),
    .inst_req_addr    (inst_req_addr),
    .inst_req_ready   (inst_req_ready),
    .inst_rdata_valid (inst_rdata_valid),
    .inst_rdata       (inst_rdata),
    .data_req_valid   (data_req_valid),
    .data_req_addr    (data_req_addr),
    .data_req_size    (data_req_size),
    .data_req_ready   (data_req_ready),
    .data_rdata_valid (data_rdata_valid),
    .data_rdata       (data_rdata),
    .bus_err          (bus_err),
    .busy             (busy),
    .axi              (bus)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] last_inst = 32'd0;
  vec_t        vecs[12];
  int          waited;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: every rdata pulse must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst && (inst_rdata_valid || data_rdata_valid || bus_err)) begin
      if (sbq.size() == 0) begin
        check("unexpected_pulse", {61'd0, inst_rdata_valid, data_rdata_valid, bus_err}, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("pulse_owner", {62'd0, inst_rdata_valid, data_rdata_valid},
              mon_e.owner ? 64'd1 : 64'd2);
        check("pulse_data", mon_e.owner ? data_rdata : inst_rdata, mon_e.data);
        check("pulse_err", bus_err, mon_e.err);
        check("pulse_cycle", cyc, mon_e.due);
      end
    end
  end

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_vec(input vec_t v, output int n);
    logic        own;
    logic        dropped;
    logic [31:0] ea;
    logic [2:0]  es;
    int          acc_cyc;
    inst_req_valid = v.inst_v;
    inst_req_addr  = v.iaddr;
    data_req_valid = v.data_v;
    data_req_addr  = v.daddr;
    data_req_size  = v.dsize;
    n = 0;
    #1;
    while (!((inst_req_valid && inst_req_ready) || (data_req_valid && data_req_ready))
           && n < WAIT_MAX) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= WAIT_MAX) begin
      check("accept_timeout", 64'd1, 64'd0);
      inst_req_valid = 1'b0;
      data_req_valid = 1'b0;
      return;
    end
    own = data_req_valid && data_req_ready;
    check("grant_owner", own, v.exp_owner);
    check("single_ready", inst_req_ready & data_req_ready, 64'd0);
    ea = own ? v.daddr : v.iaddr;
    es = own ? v.dsize : 3'b010;
    @(negedge clk);
    acc_cyc = cyc;
    inst_req_valid = 1'b0;
    data_req_valid = v.hold_data;
    for (int i = 0; i <= v.ar_dly; i++) begin
      flush   = v.flush_ar && (i == 0);
      bus.arready = (i == v.ar_dly);
      #1;
      check("ar_fields", {bus.araddr, bus.arid, bus.arsize, bus.arlen, bus.arburst, bus.arvalid},
            {ea, 3'b000, own, es, 8'd0, 2'b01, 1'b1});
      if (v.hold_data) check("data_wait_ready", data_req_ready, 64'd0);
      @(negedge clk);
    end
    bus.arready = 1'b0;
    flush = 1'b0;
    dropped = !own && (v.flush_ar || v.flush_r);
    for (int i = 0; i <= v.r_dly; i++) begin
      #1;
      check("r_state", {bus.rready, bus.arvalid, busy}, 3'b101);
      if (i == v.r_dly) begin
        bus.rvalid = 1'b1;
        bus.rid    = {3'b000, own};
        bus.rdata  = v.rdat;
        bus.rresp  = v.resp;
        bus.rlast  = 1'b1;
        flush      = v.flush_r;
        if (!dropped) begin
          sbq.push_back('{own, v.rdat, v.resp != 2'b00, acc_cyc + 2 + v.ar_dly + v.r_dly});
          if (!own) last_inst = v.rdat;
        end
      end
      @(negedge clk);
    end
    bus.rvalid = 1'b0;
    flush = 1'b0;
    #1;
    check("back_idle", {bus.arvalid, bus.rready, busy}, 64'd0);
    if (dropped) begin
      check("discard_quiet", {inst_rdata_valid, bus_err}, 64'd0);
      check("inst_rdata_hold", inst_rdata, last_inst);
    end
    if (v.hold_data) check("data_ready_after", data_req_ready, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rid     = 4'd0;
    bus.rdata   = 32'd0;
    bus.rresp   = 2'b00;
    bus.rlast   = 1'b0;

    //            inst  data  iaddr         daddr         sz    ar r  rdata         resp   fA    fR    hold  owner
    vecs[0]  = '{1'b1, 1'b1, 32'h0000_0100, 32'h8000_0000, 3'd2, 0, 0, 32'h1111_1111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 32'h0000_0104, 32'h8000_0004, 3'd1, 1, 0, 32'h2222_2222, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 32'h0000_0108, 32'h8000_0008, 3'd0, 0, 2, 32'h3333_3333, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_010C, 32'h8000_000C, 3'd2, 0, 0, 32'h4444_4444, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'hBFC0_0000, 32'h0,         3'd0, 0, 0, 32'h3C1D_8000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0,         32'h8000_1230, 3'd2, 5, 4, 32'h55AA_55AA, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h0,         32'h8000_1233, 3'd0, 0, 0, 32'h0000_00EE, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 32'hBFC0_0004, 32'h8000_2000, 3'd2, 2, 1, 32'h7777_7777, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h0,         32'h8000_2000, 3'd2, 0, 0, 32'h8888_8888, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 32'hBFC0_0008, 32'h0,         3'd0, 0, 0, 32'h9999_9999, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 32'h0000_2000, 32'h8000_3000, 3'd2, 0, 0, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_2004, 32'h8000_3004, 3'd1, 0, 0, 32'hCAFE_F00D, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    #1;
    check("reset_ctrl", {bus.arvalid, bus.rready, inst_rdata_valid, data_rdata_valid, bus_err, busy}, 64'd0);
    check("reset_ar", {bus.araddr, bus.arid, bus.arsize}, {32'd0, 4'd0, 3'b010});
    check("reset_rdata", {inst_rdata, data_rdata}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Contention, single fetch, backpressure and slave error.
    for (int k = 0; k < 7; k++) run_vec(vecs[k], waited);

    // Flush while the fetch sits in AR, with a load pending throughout.
    run_vec(vecs[7], waited);
    run_vec(vecs[8], waited);
    check("pending_load_immediate", waited, 64'd0);

    // Flush coincident with the fetch R handshake, SLVERR response.
    run_vec(vecs[9], waited);

    // Reset while in the R state.
    inst_req_valid = 1'b1;
    inst_req_addr  = 32'h0000_1000;
    @(negedge clk);
    inst_req_valid = 1'b0;
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    #1;
    check("pre_reset_r", {bus.rready, busy}, 2'b11);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_drop", {bus.arvalid, bus.rready, busy}, 64'd0);
    check("async_reset_regs", {inst_rdata, bus.araddr, bus.arsize}, {32'd0, 32'd0, 3'b010});
    last_inst = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    run_vec(vecs[10], waited);
    run_vec(vecs[11], waited);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
